// File: rtl/lfsr_gal_mw.sv
// lfsr_gal_mw
// Multi-bit Galois LFSR generator / scrambler with a valid/ready output stream.
// Each accepted word advances the register by OW single-bit Galois steps,
// unrolled combinationally. Taps and fill can be reloaded at run time, and
// o_sync marks a word that began at the loaded fill state.
//
// Ports:
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   i_ce        enable word generation
//   i_mode      0 = generator (feedback input 0), 1 = scrambler (i_data fed in)
//   i_data      scrambler input bits, consumed LSB first
//   i_load      load i_taps / i_fill this cycle (priority over advance)
//   i_taps      new Galois tap mask
//   i_fill      new fill (zero is replaced by INITIAL_FILL)
//   i_ready     downstream accepts o_word
//   o_valid     o_word valid
//   o_word      output bits, LSB = earliest bit
//   o_sync      word began at the loaded fill state
//   o_fill_err  one-cycle pulse: a zero fill was loaded and replaced
module lfsr_gal_mw #(
    parameter int              LN           = 8,
    parameter int              OW           = 4,
    parameter logic [LN-1:0]   TAPS         = LN'(8'hb4),
    parameter logic [LN-1:0]   INITIAL_FILL = LN'(1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_mode,
    input  logic [OW-1:0] i_data,
    input  logic          i_load,
    input  logic [LN-1:0] i_taps,
    input  logic [LN-1:0] i_fill,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [OW-1:0] o_word,
    output logic          o_sync,
    output logic          o_fill_err
);

    // One Galois step: shift right, new bit enters at the top, and the
    // bit leaving at the bottom folds the tap mask back in (carry-free XOR).
    function automatic logic [LN-1:0] gal_step(
        input logic [LN-1:0] s,
        input logic          b,
        input logic [LN-1:0] t
    );
        return {b, s[LN-1:1]} ^ (s[0] ? t : '0);
    endfunction

    logic [LN-1:0] sreg;
    logic [LN-1:0] taps_r;
    logic [LN-1:0] fill_r;

    logic [LN-1:0] walk;
    logic [LN-1:0] sreg_nxt;
    logic [OW-1:0] bits_c;
    logic          adv;
    logic          fill_zero;

    logic          vld_p1;
    logic [OW-1:0] word_p1;
    logic          sync_p1;
    logic          fill_err_p1;

    // Unroll OW steps; step k emits bit k and consumes i_data[k] in scrambler mode.
    always_comb begin
        walk   = sreg;
        bits_c = '0;
        for (int k = 0; k < OW; k++) begin
            bits_c[k] = walk[0];
            walk      = gal_step(walk, i_mode & i_data[k], taps_r);
        end
        sreg_nxt = walk;
    end

    // Advance when enabled and the output slot is empty or being drained now.
    assign adv       = i_ce && !i_load && (!vld_p1 || i_ready);
    assign fill_zero = (i_fill == '0);

    // Stage p1: output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg        <= INITIAL_FILL;
            taps_r      <= TAPS;
            fill_r      <= INITIAL_FILL;
            vld_p1      <= 1'b0;
            word_p1     <= '0;
            sync_p1     <= 1'b0;
            fill_err_p1 <= 1'b0;
        end else begin
            fill_err_p1 <= 1'b0;
            if (i_load) begin
                // A zero fill would lock the register; substitute the default.
                taps_r      <= i_taps;
                sreg        <= fill_zero ? INITIAL_FILL : i_fill;
                fill_r      <= fill_zero ? INITIAL_FILL : i_fill;
                fill_err_p1 <= fill_zero;
                vld_p1      <= 1'b0;
            end else if (adv) begin
                sreg    <= sreg_nxt;
                word_p1 <= bits_c;
                sync_p1 <= (sreg == fill_r);
                vld_p1  <= 1'b1;
            end else if (vld_p1 && i_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign o_valid    = vld_p1;
    assign o_word     = word_p1;
    assign o_sync     = sync_p1;
    assign o_fill_err = fill_err_p1;

endmodule

// File: tb/tb_lfsr_gal_mw.sv
// Testbench for lfsr_gal_mw: randomized stimulus against a bit-serial
// reference model of the register plus a transaction-level handshake model.
module tb_lfsr_gal_mw;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ce = 1'b0;
    logic       i_mode = 1'b0;
    logic [3:0] i_data = '0;
    logic       i_load = 1'b0;
    logic [7:0] i_taps = '0;
    logic [7:0] i_fill = '0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [3:0] o_word;
    logic       o_sync;
    logic       o_fill_err;

    logic       ce1 = 1'b0;
    logic       ready1 = 1'b1;
    logic [0:0] data1 = '0;
    logic       load1 = 1'b0;
    logic [7:0] taps1 = '0;
    logic [7:0] fill1 = '0;
    logic       o_valid1;
    logic [0:0] o_word1;
    logic       o_sync1;
    logic       o_fill_err1;

    always #5 i_clk = ~i_clk;

    lfsr_gal_mw #(.LN(8), .OW(4), .TAPS(8'hb4), .INITIAL_FILL(8'h01)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_mode(i_mode),
        .i_data(i_data), .i_load(i_load), .i_taps(i_taps), .i_fill(i_fill),
        .i_ready(i_ready), .o_valid(o_valid), .o_word(o_word),
        .o_sync(o_sync), .o_fill_err(o_fill_err)
    );

    lfsr_gal_mw #(.LN(8), .OW(1), .TAPS(8'hb4), .INITIAL_FILL(8'h01)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(ce1), .i_mode(1'b0),
        .i_data(data1), .i_load(load1), .i_taps(taps1), .i_fill(fill1),
        .i_ready(ready1), .o_valid(o_valid1), .o_word(o_word1),
        .o_sync(o_sync1), .o_fill_err(o_fill_err1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: four bit-serial Galois steps written as plain arithmetic.
    task automatic gal_word(input bit [7:0] s, input bit [7:0] t, input bit mode,
                            input bit [3:0] d, output bit [3:0] w, output bit [7:0] ns);
        bit o;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            o    = s[0];
            w[k] = o;
            s    = (s >> 1) + ((mode && d[k]) ? 8'h80 : 8'h00);
            if (o) s = s ^ t;
        end
        ns = s;
    endtask

    bit [3:0] gold [0:511];

    task automatic gold_fill(input bit [7:0] s, input bit [7:0] t);
        bit [3:0] w;
        bit [7:0] ns;
        for (int i = 0; i < 512; i++) begin
            gal_word(s, t, 1'b0, 4'h0, w, ns);
            gold[i] = w;
            s = ns;
        end
    endtask

    // Model state for the 4-bit instance.
    bit [7:0] m_s = 8'h01, m_t = 8'hb4, m_f = 8'h01;
    bit       m_v = 0, m_sy = 0, m_fe = 0;
    bit [3:0] m_w = 0;

    // Golden bit-serial state for the 1-bit instance.
    bit [7:0] g1 = 8'h01;
    int       n_sync1 = 0;

    bit       rec = 0;
    bit [3:0] acc[$];

    task automatic tick(input bit rst, input bit ld, input bit ce, input bit mode,
                        input bit [3:0] d, input bit [7:0] t, input bit [7:0] f,
                        input bit rdy);
        bit [7:0] n_s, n_t, n_f, ns;
        bit       n_v, n_sy, n_fe, pre_v, c1, e1_bit, e1_sy;
        bit [3:0] n_w, pre_w, w;
        i_reset = rst; i_load = ld; i_ce = ce; i_mode = mode;
        i_data = d; i_taps = t; i_fill = f; i_ready = rdy;
        pre_v = o_valid;
        pre_w = o_word;
        if (rec && o_valid && rdy && !ld && !rst) acc.push_back(o_word);
        n_s = m_s; n_t = m_t; n_f = m_f; n_v = m_v; n_w = m_w; n_sy = m_sy; n_fe = m_fe;
        if (rst) begin
            n_s = 8'h01; n_t = 8'hb4; n_f = 8'h01; n_v = 0; n_w = 0; n_sy = 0; n_fe = 0;
        end else begin
            n_fe = 0;
            if (ld) begin
                n_t  = t;
                n_f  = (f == 0) ? 8'h01 : f;
                n_s  = n_f;
                n_fe = (f == 0);
                n_v  = 0;
            end else if (ce && (!m_v || rdy)) begin
                gal_word(m_s, m_t, mode, d, w, ns);
                n_w  = w;
                n_sy = (m_s == m_f);
                n_s  = ns;
                n_v  = 1;
            end else if (m_v && rdy) begin
                n_v = 0;
            end
        end
        c1 = ce1 && !rst;
        e1_bit = g1[0];
        e1_sy  = (g1 == 8'h01);
        if (c1) g1 = (g1 >> 1) ^ (e1_bit ? 8'hb4 : 8'h00);
        @(posedge i_clk);
        #1;
        m_s = n_s; m_t = n_t; m_f = n_f; m_v = n_v; m_w = n_w; m_sy = n_sy; m_fe = n_fe;
        chk("valid", 32'(o_valid), 32'(m_v));
        if (m_v) begin
            chk("word", 32'(o_word), 32'(m_w));
            chk("sync", 32'(o_sync), 32'(m_sy));
        end
        chk("fill_err", 32'(o_fill_err), 32'(m_fe));
        if (pre_v && !rdy && !ld && !rst) chk("stall_hold", 32'(o_word), 32'(pre_w));
        if (c1) begin
            chk("ow1_valid", 32'(o_valid1), 32'd1);
            chk("ow1_word", 32'(o_word1), 32'(e1_bit));
            chk("ow1_sync", 32'(o_sync1), 32'(e1_sy));
            if (o_sync1) n_sync1++;
        end
    endtask

    task automatic run(input bit ce, input bit mode, input bit [3:0] d, input bit rdy);
        tick(1'b0, 1'b0, ce, mode, d, 8'h00, 8'h00, rdy);
    endtask

    task automatic load(input bit [7:0] t, input bit [7:0] f);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, t, f, 1'b1);
    endtask

    initial begin
        int mid_syncs;
        bit ld;
        bit [7:0] f;

        // Reset
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_word", 32'(o_word), 32'd0);
        chk("rst_sync", 32'(o_sync), 32'd0);
        chk("rst_fill_err", 32'(o_fill_err), 32'd0);

        // Generator with defaults, period / sync; OW=1 instance runs alongside
        ce1 = 1'b1;
        mid_syncs = 0;
        for (int k = 0; k < 520; k++) begin
            run(1'b1, 1'b0, 4'h0, 1'b1);
            if (k == 0) begin
                chk("first_word", 32'(o_word), 32'h9);
                chk("sync_w0", 32'(o_sync), 32'd1);
            end else if (k == 1) begin
                chk("second_word", 32'(o_word), 32'(gold_second()));
            end
            if (k == 255) chk("sync_w255", 32'(o_sync), 32'd1);
            else if (k > 0 && k < 255 && o_sync) mid_syncs++;
        end
        chk("sync_mid_count", 32'(mid_syncs), 32'd0);
        chk("ow1_sync_count", 32'(n_sync1), 32'd3);
        ce1 = 1'b0;

        // Backpressure: accepted stream must equal the unstalled sequence
        load(8'hb4, 8'h01);
        acc.delete();
        rec = 1;
        for (int k = 0; k < 200; k++)
            run(($urandom_range(0, 7) != 0), 1'b0, 4'h0, $urandom_range(0, 1) == 1);
        rec = 0;
        gold_fill(8'h01, 8'hb4);
        chk("bp_enough_words", 32'(acc.size() >= 40), 32'd1);
        for (int i = 0; i < acc.size(); i++) chk("bp_stream", 32'(acc[i]), 32'(gold[i]));

        // Mid-stream load of new taps and fill
        for (int k = 0; k < 5; k++) run(1'b1, 1'b0, 4'h0, 1'b1);
        load(8'hb8, 8'h5a);
        chk("load_valid_low", 32'(o_valid), 32'd0);
        gold_fill(8'h5a, 8'hb8);
        run(1'b1, 1'b0, 4'h0, 1'b1);
        chk("load_first_word", 32'(o_word), 32'(gold[0]));
        chk("load_first_sync", 32'(o_sync), 32'd1);
        for (int k = 1; k < 20; k++) begin
            run(1'b1, 1'b0, 4'h0, 1'b1);
            chk("load_stream", 32'(o_word), 32'(gold[k]));
        end

        // Zero fill load
        load(8'hb4, 8'h00);
        chk("zero_fill_err", 32'(o_fill_err), 32'd1);
        run(1'b1, 1'b0, 4'h0, 1'b1);
        chk("zero_fill_err_clr", 32'(o_fill_err), 32'd0);
        chk("zero_fill_word", 32'(o_word), 32'h9);
        chk("zero_fill_sync", 32'(o_sync), 32'd1);

        // Scrambler with random data, stalls and occasional reloads
        for (int k = 0; k < 300; k++) begin
            ld = ($urandom_range(0, 24) == 0);
            f  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick(1'b0, ld, ($urandom_range(0, 5) != 0), 1'b1, 4'($urandom),
                 8'($urandom), f, $urandom_range(0, 2) != 0);
        end

        // Scrambler with all-zero data reproduces the generator
        load(8'hb4, 8'h01);
        gold_fill(8'h01, 8'hb4);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1);
            chk("scr_zero_eq_gen", 32'(o_word), 32'(gold[k]));
        end

        // Reset during a stall together with a load
        run(1'b1, 1'b0, 4'h0, 1'b0);
        run(1'b1, 1'b0, 4'h0, 1'b0);
        chk("pre_rst_stalled", 32'(o_valid), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'hff, 8'h33, 1'b1);
        chk("rst2_valid", 32'(o_valid), 32'd0);
        chk("rst2_word", 32'(o_word), 32'd0);
        chk("rst2_sync", 32'(o_sync), 32'd0);
        chk("rst2_fill_err", 32'(o_fill_err), 32'd0);
        run(1'b1, 1'b0, 4'h0, 1'b1);
        chk("rst2_word_taps", 32'(o_word), 32'h9);
        chk("rst2_sync_fill", 32'(o_sync), 32'd1);
        run(1'b1, 1'b0, 4'h0, 1'b1);
        chk("rst2_second", 32'(o_word), 32'(gold_second()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Second word from the default fill and taps, derived from the reference steps.
    function automatic bit [3:0] gold_second();
        bit [7:0] s;
        bit [3:0] w;
        bit       o;
        s = 8'h01;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            o = s[0];
            if (k >= 4) w[k-4] = o;
            s = s >> 1;
            if (o) s = s ^ 8'hb4;
        end
        return w;
    endfunction

endmodule
